// File: rtl/ctrl_pkg.sv
// Shared control definitions for the 16-bit core sequencer: state encoding,
// opcode/func constants and writeback source selects.
package ctrl_pkg;

   // Encodings are visible on state_o and must stay fixed.
   typedef enum logic [2:0] {
      StFetch  = 3'd0,
      StDecode = 3'd1,
      StExec   = 3'd2,
      StMem    = 3'd3,
      StWb     = 3'd4,
      StHalt   = 3'd5,
      StFault  = 3'd6
   } state_t;

   localparam logic [1:0] OP_ALU = 2'd0;
   localparam logic [1:0] OP_IMM = 2'd1;
   localparam logic [1:0] OP_MEM = 2'd2;
   localparam logic [1:0] OP_BR  = 2'd3;

   localparam logic [2:0] FUNC_HALT = 3'd7;
   localparam logic [2:0] ALU_ADD   = 3'd0;

   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;

   // HALT shares the register-ALU opcode and is picked out by its func code.
   function automatic logic is_halt(input logic [1:0] op, input logic [2:0] fn);
      return (op == OP_ALU) && (fn == FUNC_HALT);
   endfunction

endpackage

// File: rtl/wait_timer.sv
// Memory handshake wait counter. Counts cycles spent waiting for ready and
// flags expiry once the count reaches WAIT_LIMIT. WAIT_LIMIT = 0 never expires.
module wait_timer #(
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic inc,
   output logic expired
);

   localparam int unsigned CntW = (WAIT_LIMIT == 0) ? 1 : $clog2(WAIT_LIMIT + 1);
   localparam logic [CntW-1:0] Limit = CntW'(WAIT_LIMIT);

   logic [CntW-1:0] cnt_q, cnt_d;

   // Clear has priority; saturate at the limit so the count never wraps.
   always_comb begin
      cnt_d = cnt_q;
      if (clr) begin
         cnt_d = '0;
      end else if (inc && (cnt_q != Limit)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = (WAIT_LIMIT != 0) && (cnt_q == Limit);

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM for the 16-bit core: fetch, decode, execute,
// memory and writeback with one instruction in flight. Traps into sticky
// HALT / FAULT states. Optional macro PERF_COUNTERS_EN adds retired/stall
// counters.
module instr_sequencer
   import ctrl_pkg::*;
#(
   parameter int unsigned WAIT_LIMIT = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [1:0]  opcode,
   input  logic [2:0]  func,
   input  logic        zero_flag,
   output logic        imem_req,
   input  logic        imem_ready,
   output logic        ir_load,
   output logic        dmem_req,
   output logic        dmem_we,
   input  logic        dmem_ready,
   output logic        pc_inc,
   output logic        pc_load,
   output logic        reg_we,
   output logic [1:0]  wb_sel,
   output logic [2:0]  alu_op,
   output logic        alu_src_imm,
   output logic        halted,
   output logic        fault,
   output logic [2:0]  state_o
`ifdef PERF_COUNTERS_EN
   ,
   output logic [31:0] retired_cnt,
   output logic [31:0] stall_cnt
`endif
);

   state_t     state_q, state_d;
   logic [1:0] op_q, op_d;
   logic [2:0] func_q, func_d;
   logic       wait_clr, wait_inc, wait_expired;

   // Any state change clears the wait count, which covers entry into FETCH and MEM.
   assign wait_clr = (state_d != state_q);
   assign wait_inc = ((state_q == StFetch) && !imem_ready) ||
                     ((state_q == StMem) && !dmem_ready);

   wait_timer #(
      .WAIT_LIMIT (WAIT_LIMIT)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (wait_clr),
      .inc     (wait_inc),
      .expired (wait_expired)
   );

   // Next-state and strobe decode; strobes are gated by rst_n so they drop
   // the instant reset asserts rather than at the next edge.
   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      func_d      = func_q;
      imem_req    = 1'b0;
      ir_load     = 1'b0;
      dmem_req    = 1'b0;
      dmem_we     = 1'b0;
      pc_inc      = 1'b0;
      pc_load     = 1'b0;
      reg_we      = 1'b0;
      wb_sel      = WB_ALU;
      alu_op      = ALU_ADD;
      alu_src_imm = 1'b0;
      halted      = 1'b0;
      fault       = 1'b0;
      if (rst_n) begin
         unique case (state_q)
            StFetch: begin
               imem_req = 1'b1;
               ir_load  = imem_ready;
               // Ready in the same cycle as expiry still wins.
               if (imem_ready) begin
                  state_d = StDecode;
               end else if (wait_expired) begin
                  state_d = StFault;
               end
            end
            StDecode: begin
               op_d    = opcode;
               func_d  = func;
               pc_inc  = 1'b1;
               state_d = is_halt(opcode, func) ? StHalt : StExec;
            end
            StExec: begin
               unique case (op_q)
                  OP_ALU: begin
                     alu_op  = func_q;
                     state_d = StWb;
                  end
                  OP_IMM: begin
                     alu_src_imm = 1'b1;
                     state_d     = StWb;
                  end
                  OP_MEM: begin
                     // Address = base + kk through the ALU.
                     alu_src_imm = 1'b1;
                     state_d     = StMem;
                  end
                  default: begin
                     pc_load = zero_flag;
                     state_d = StFetch;
                  end
               endcase
            end
            StMem: begin
               dmem_req = 1'b1;
               dmem_we  = func_q[0];
               if (dmem_ready) begin
                  state_d = func_q[0] ? StFetch : StWb;
               end else if (wait_expired) begin
                  state_d = StFault;
               end
            end
            StWb: begin
               reg_we  = 1'b1;
               wb_sel  = (op_q == OP_MEM) ? WB_MEM : WB_ALU;
               state_d = StFetch;
            end
            StHalt: begin
               halted = 1'b1;
            end
            StFault: begin
               fault = 1'b1;
            end
            default: begin
               state_d = StFault;
            end
         endcase
      end
   end

   // State and captured decode fields.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StFetch;
         op_q    <= 2'd0;
         func_q  <= 3'd0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         func_q  <= func_d;
      end
   end

   assign state_o = state_q;

`ifdef PERF_COUNTERS_EN
   logic        retire;
   logic [31:0] retired_q, stall_q;

   assign retire = (state_q == StWb) ||
                   ((state_q == StMem) && dmem_ready && func_q[0]) ||
                   ((state_q == StExec) && (op_q == OP_BR)) ||
                   ((state_q == StDecode) && is_halt(opcode, func));

   // Free-running event counters, wrapping at 2^32.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         retired_q <= '0;
         stall_q   <= '0;
      end else begin
         if (retire) begin
            retired_q <= retired_q + 32'd1;
         end
         if (wait_inc) begin
            stall_q <= stall_q + 32'd1;
         end
      end
   end

   assign retired_cnt = retired_q;
   assign stall_cnt   = stall_q;
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer. A per-instruction model builds the
// expected output vector for every cycle from the instruction rules; one
// negedge process compares the DUT against that queue.
module tb_instr_sequencer;

   localparam int unsigned WL = 4;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  opcode;
   logic [2:0]  func;
   logic        zero_flag, imem_ready, dmem_ready;
   logic        imem_req, ir_load, dmem_req, dmem_we, pc_inc, pc_load, reg_we;
   logic [1:0]  wb_sel;
   logic [2:0]  alu_op;
   logic        alu_src_imm, halted, fault;
   logic [2:0]  state_o;
`ifdef PERF_COUNTERS_EN
   logic [31:0] retired_cnt, stall_cnt;
`endif

   instr_sequencer #(
      .WAIT_LIMIT (WL)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .opcode      (opcode),
      .func        (func),
      .zero_flag   (zero_flag),
      .imem_req    (imem_req),
      .imem_ready  (imem_ready),
      .ir_load     (ir_load),
      .dmem_req    (dmem_req),
      .dmem_we     (dmem_we),
      .dmem_ready  (dmem_ready),
      .pc_inc      (pc_inc),
      .pc_load     (pc_load),
      .reg_we      (reg_we),
      .wb_sel      (wb_sel),
      .alu_op      (alu_op),
      .alu_src_imm (alu_src_imm),
      .halted      (halted),
      .fault       (fault),
      .state_o     (state_o)
`ifdef PERF_COUNTERS_EN
      ,
      .retired_cnt (retired_cnt),
      .stall_cnt   (stall_cnt)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [2:0] state;
      logic       imem_req, ir_load, dmem_req, dmem_we, pc_inc, pc_load, reg_we;
      logic [1:0] wb_sel;
      logic [2:0] alu_op;
      logic       alu_src_imm, halted, fault;
   } out_t;

   out_t act;
   assign act = {state_o, imem_req, ir_load, dmem_req, dmem_we, pc_inc, pc_load, reg_we,
                 wb_sel, alu_op, alu_src_imm, halted, fault};

   out_t exp_q[$];
   int   nerr = 0;
   int   nchk = 0;
   int   retired_m = 0;
   int   stall_m = 0;
   int   n_pc_inc = 0, n_pc_load = 0, n_reg_we = 0, n_dmem_req = 0, n_imem_req = 0;

   task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
      nchk++;
      if (a !== e) begin
         nerr++;
         $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, a, e);
      end
   endtask

   // Compare process: one expected vector per driven cycle, plus strobe tallies.
   always @(negedge clk) begin
      out_t e;
      if (exp_q.size() != 0) begin
         e = exp_q.pop_front();
         check("cycle_outputs", act, e);
      end
      if (rst_n) begin
         if (pc_inc)   n_pc_inc++;
         if (pc_load)  n_pc_load++;
         if (reg_we)   n_reg_we++;
         if (dmem_req) n_dmem_req++;
         if (imem_req) n_imem_req++;
      end
   end

   task automatic clr_cnt();
      n_pc_inc = 0; n_pc_load = 0; n_reg_we = 0; n_dmem_req = 0; n_imem_req = 0;
   endtask

   // Called at posedge+1: applies inputs for the current cycle, queues its
   // expectation, then advances to the next cycle.
   task automatic drive(input logic [1:0] op, input logic [2:0] fn, input logic zf,
                        input logic ir, input logic dr, input out_t e);
      opcode = op; func = fn; zero_flag = zf; imem_ready = ir; dmem_ready = dr;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
   endtask

   // One complete instruction: fw fetch waits, mw data-memory waits.
   task automatic issue(input logic [1:0] op, input logic [2:0] fn, input logic zf,
                        input int fw, input int mw);
      out_t e;
      for (int i = 0; i <= fw; i++) begin
         e = '0; e.state = 3'd0; e.imem_req = 1'b1; e.ir_load = (i == fw);
         drive(op, fn, zf, (i == fw), 1'b0, e);
      end
      stall_m += fw;
      e = '0; e.state = 3'd1; e.pc_inc = 1'b1;
      drive(op, fn, zf, 1'b0, 1'b0, e);
      if (op == 2'd0 && fn == 3'd7) begin
         retired_m++;
         return;
      end
      e = '0; e.state = 3'd2;
      if (op == 2'd0) e.alu_op = fn;
      else if (op != 2'd3) e.alu_src_imm = 1'b1;
      else e.pc_load = zf;
      drive(op, fn, zf, 1'b0, 1'b0, e);
      if (op == 2'd3) begin
         retired_m++;
         return;
      end
      if (op == 2'd2) begin
         for (int j = 0; j <= mw; j++) begin
            e = '0; e.state = 3'd3; e.dmem_req = 1'b1; e.dmem_we = fn[0];
            drive(op, fn, zf, 1'b0, (j == mw), e);
         end
         stall_m += mw;
         if (fn[0]) begin
            retired_m++;
            return;
         end
      end
      e = '0; e.state = 3'd4; e.reg_we = 1'b1; e.wb_sel = (op == 2'd2) ? 2'd1 : 2'd0;
      drive(op, fn, zf, 1'b0, 1'b0, e);
      retired_m++;
   endtask

   // Entered at posedge+1; asserts reset mid-cycle and checks outputs drop at once.
   task automatic do_reset();
      #3;
      rst_n = 1'b0;
      imem_ready = 1'b0;
      dmem_ready = 1'b0;
      #1;
      check("reset_outputs", act, 32'd0);
      check("reset_state", state_o, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      retired_m = 0;
      stall_m = 0;
      clr_cnt();
   endtask

   task automatic perf_check(input string tag, input int r_lit, input int s_lit);
`ifdef PERF_COUNTERS_EN
      check({tag, "_retired_model"}, retired_cnt, retired_m);
      check({tag, "_stall_model"}, stall_cnt, stall_m);
      if (r_lit >= 0) check({tag, "_retired_lit"}, retired_cnt, r_lit);
      if (s_lit >= 0) check({tag, "_stall_lit"}, stall_cnt, s_lit);
`endif
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      out_t e;
      rst_n = 1'b0;
      opcode = 2'd0; func = 3'd0; zero_flag = 1'b0; imem_ready = 1'b0; dmem_ready = 1'b0;
      #1;
      check("por_outputs", act, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Three instructions, the first with two fetch stalls.
      issue(2'd0, 3'd3, 1'b0, 2, 0);
      issue(2'd1, 3'd0, 1'b0, 0, 0);
      issue(2'd3, 3'd0, 1'b1, 0, 0);
      check("mix_pc_inc", n_pc_inc, 32'd3);
      check("mix_pc_load", n_pc_load, 32'd1);
      check("mix_reg_we", n_reg_we, 32'd2);
      perf_check("mix", 3, 2);
      do_reset();

      // Register ALU op with ready held.
      issue(2'd0, 3'd3, 1'b0, 0, 0);
      check("alu_pc_inc", n_pc_inc, 32'd1);
      check("alu_reg_we", n_reg_we, 32'd1);
      clr_cnt();

      // Load with three data waits.
      issue(2'd2, 3'd0, 1'b0, 0, 3);
      check("load_dmem_req_cycles", n_dmem_req, 32'd4);
      check("load_reg_we", n_reg_we, 32'd1);
      clr_cnt();

      // Store with one data wait: no writeback.
      issue(2'd2, 3'd1, 1'b0, 0, 1);
      check("store_dmem_req_cycles", n_dmem_req, 32'd2);
      check("store_reg_we", n_reg_we, 32'd0);
      clr_cnt();

      // Branch taken then not taken.
      issue(2'd3, 3'd5, 1'b1, 0, 0);
      check("br_taken_pc_load", n_pc_load, 32'd1);
      check("br_taken_pc_inc", n_pc_inc, 32'd1);
      clr_cnt();
      issue(2'd3, 3'd5, 1'b0, 0, 0);
      check("br_not_taken_pc_load", n_pc_load, 32'd0);
      check("br_not_taken_pc_inc", n_pc_inc, 32'd1);
      perf_check("seq", 5, 4);
      do_reset();

      // Fetch never ready: WL+1 FETCH cycles, then sticky FAULT.
      for (int i = 0; i <= int'(WL); i++) begin
         e = '0; e.state = 3'd0; e.imem_req = 1'b1;
         drive(2'd0, 3'd0, 1'b0, 1'b0, 1'b0, e);
      end
      for (int i = 0; i < 3; i++) begin
         e = '0; e.state = 3'd6; e.fault = 1'b1;
         drive(2'd0, 3'd0, 1'b0, 1'b1, 1'b1, e);
      end
      check("timeout_fault", fault, 32'd1);
      check("timeout_fetch_cycles", n_imem_req, 32'd5);
      do_reset();

      // Ready on the limit cycle wins over the timeout.
      issue(2'd0, 3'd1, 1'b0, int'(WL), 0);
      check("limit_ready_no_fault", fault, 32'd0);
      check("limit_ready_reg_we", n_reg_we, 32'd1);
      clr_cnt();

      // HALT: sticky, no further fetches even with ready asserted.
      issue(2'd0, 3'd7, 1'b0, 0, 0);
      for (int i = 0; i < 4; i++) begin
         e = '0; e.state = 3'd5; e.halted = 1'b1;
         drive(2'd0, 3'd0, 1'b1, 1'b1, 1'b1, e);
      end
      check("halt_halted", halted, 32'd1);
      check("halt_imem_req_cycles", n_imem_req, 32'd1);
      check("halt_pc_inc", n_pc_inc, 32'd1);
      perf_check("halt", 2, 4);
      do_reset();

      // Reset while a load sits in MEM.
      e = '0; e.state = 3'd0; e.imem_req = 1'b1; e.ir_load = 1'b1;
      drive(2'd2, 3'd0, 1'b0, 1'b1, 1'b0, e);
      e = '0; e.state = 3'd1; e.pc_inc = 1'b1;
      drive(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, e);
      e = '0; e.state = 3'd2; e.alu_src_imm = 1'b1;
      drive(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, e);
      e = '0; e.state = 3'd3; e.dmem_req = 1'b1;
      drive(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, e);
      drive(2'd2, 3'd0, 1'b0, 1'b0, 1'b0, e);
      check("pre_reset_in_mem", state_o, 32'd3);
      do_reset();

      // Normal operation resumes after reset.
      issue(2'd1, 3'd2, 1'b0, 1, 0);
      check("post_reset_reg_we", n_reg_we, 32'd1);
      perf_check("post_reset", 1, 1);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
